// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: branch type encodings,
// the buffered entry layout and the branch decision helper.
package alu_result_stage_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_ZERO   = 2'b01,
        BR_NZERO  = 2'b10,
        BR_ALWAYS = 2'b11
    } br_type_e;

    // Entry layout, MSB to LSB: {result, dest, wr_en, br_taken}
    localparam int unsigned ENT_BR_BIT   = 0;
    localparam int unsigned ENT_WR_BIT   = 1;
    localparam int unsigned ENT_DEST_LSB = 2;

    function automatic logic br_decide(input logic [1:0] br_type, input logic zero);
        logic taken;
        case (br_type_e'(br_type))
            BR_NONE:   taken = 1'b0;
            BR_ZERO:   taken = zero;
            BR_NZERO:  taken = ~zero;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// result_fifo: DEPTH x EW synchronous FIFO exposing the oldest (head)
// and the most recently pushed (tail) entries.
module result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EW    = 22
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [EW-1:0]              i_data,
    output logic [EW-1:0]              o_head,
    output logic [EW-1:0]              o_tail,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_tail_ptr;

    // Entry storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status flags and head/tail read ports
    always_comb begin
        w_tail_ptr = r_wr_ptr - AW'(1);
        o_head     = r_mem[r_rd_ptr];
        o_tail     = r_mem[w_tail_ptr];
        o_full     = (r_count == CW'(DEPTH));
        o_empty    = (r_count == '0);
        o_count    = r_count;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage output register: decodes branch/write enable at push, buffers
// entries toward writeback, forwards the youngest entry and counts retirements.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [RW-1:0]    in_dest,
    input  logic             in_wr_en,
    input  logic [1:0]       in_br_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RW-1:0]    out_dest,
    output logic             out_wr_en,
    output logic             out_br_taken,
    output logic             fwd_valid,
    output logic [RW-1:0]    fwd_dest,
    output logic [WIDTH-1:0] fwd_result,
    output logic [15:0]      retire_count
);
    localparam int unsigned EW    = WIDTH + RW + 2;
    localparam int unsigned R_LSB = ENT_DEST_LSB + RW;

    logic [EW-1:0]          w_entry_in;
    logic [EW-1:0]          w_head;
    logic [EW-1:0]          w_tail;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_push;
    logic                   w_pop;
    logic [15:0]            r_retire;

    // Decode at push: r0 writes suppressed, branch resolved from the zero flag
    always_comb begin
        w_entry_in = {alu_result, in_dest, in_wr_en && (in_dest != '0),
                      br_decide(in_br_type, alu_zero)};
        in_ready   = ~reset & ~w_full;
        out_valid  = ~reset & ~w_empty;
        w_push     = in_valid & in_ready;
        w_pop      = out_valid & out_ready;
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry_in),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Head and forwarding outputs, zeroed when no qualifying entry exists
    always_comb begin
        out_result   = '0;
        out_dest     = '0;
        out_wr_en    = 1'b0;
        out_br_taken = 1'b0;
        fwd_valid    = ~reset & ~w_empty & w_tail[ENT_WR_BIT];
        fwd_dest     = '0;
        fwd_result   = '0;
        if (out_valid) begin
            out_result   = w_head[EW-1:R_LSB];
            out_dest     = w_head[R_LSB-1:ENT_DEST_LSB];
            out_wr_en    = w_head[ENT_WR_BIT];
            out_br_taken = w_head[ENT_BR_BIT];
        end
        if (fwd_valid) begin
            fwd_result = w_tail[EW-1:R_LSB];
            fwd_dest   = w_tail[R_LSB-1:ENT_DEST_LSB];
        end
        retire_count = reset ? '0 : r_retire;
    end

    // Retirement counter; wraps modulo 2^16
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire <= '0;
        end else if (w_pop) begin
            r_retire <= r_retire + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage with a queue-based reference model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic [3:0]  in_dest;
    logic        in_wr_en;
    logic [1:0]  in_br_type;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_dest;
    logic        out_wr_en;
    logic        out_br_taken;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [15:0] fwd_result;
    logic [15:0] retire_count;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16), .DEPTH(DEPTH), .RW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .in_dest(in_dest),
        .in_wr_en(in_wr_en), .in_br_type(in_br_type), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
        .out_wr_en(out_wr_en), .out_br_taken(out_br_taken), .fwd_valid(fwd_valid),
        .fwd_dest(fwd_dest), .fwd_result(fwd_result), .retire_count(retire_count)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  dest;
        logic        wr;
        logic        br;
    } ent_t;

    ent_t q[$];
    int   m_retire = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Compare every output against the model state
    task automatic compare_all();
        ent_t h, t;
        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_result", out_result, 0);
            check("rst_out_dest", out_dest, 0);
            check("rst_out_wr", out_wr_en, 0);
            check("rst_out_br", out_br_taken, 0);
            check("rst_fwd_valid", fwd_valid, 0);
            check("rst_fwd_dest", fwd_dest, 0);
            check("rst_fwd_result", fwd_result, 0);
            check("rst_retire", retire_count, 0);
        end else begin
            check("in_ready", in_ready, q.size() < DEPTH);
            check("out_valid", out_valid, q.size() > 0);
            check("retire", retire_count, m_retire);
            if (q.size() > 0) begin
                h = q[0];
                t = q[q.size()-1];
                check("out_result", out_result, h.res);
                check("out_dest", out_dest, h.dest);
                check("out_wr", out_wr_en, h.wr);
                check("out_br", out_br_taken, h.br);
                check("fwd_valid", fwd_valid, t.wr);
                check("fwd_dest", fwd_dest, t.wr ? t.dest : 4'd0);
                check("fwd_result", fwd_result, t.wr ? t.res : 16'd0);
            end else begin
                check("e_out_result", out_result, 0);
                check("e_out_dest", out_dest, 0);
                check("e_out_wr", out_wr_en, 0);
                check("e_out_br", out_br_taken, 0);
                check("e_fwd_valid", fwd_valid, 0);
                check("e_fwd_dest", fwd_dest, 0);
                check("e_fwd_result", fwd_result, 0);
            end
        end
    endtask

    // One clock with the current inputs; the model advances at the edge
    task automatic tick();
        bit   do_push, do_pop, was_rst;
        ent_t e;
        was_rst = reset;
        do_push = !reset && in_valid && (q.size() < DEPTH);
        do_pop  = !reset && out_ready && (q.size() > 0);
        e.res  = alu_result;
        e.dest = in_dest;
        e.wr   = in_wr_en && (in_dest != 0);
        e.br   = (in_br_type == 2'd3) || (in_br_type == 2'd1 && alu_zero) ||
                 (in_br_type == 2'd2 && !alu_zero);
        @(posedge clk);
        if (was_rst) begin
            q.delete();
            m_retire = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                m_retire = (m_retire + 1) % 65536;
            end
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [15:0] r, input bit z,
                         input logic [3:0] d, input bit w, input logic [1:0] b, input bit rdy);
        in_valid = v; alu_result = r; alu_zero = z; in_dest = d;
        in_wr_en = w; in_br_type = b; out_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 compare_all();
    endtask

    initial begin
        // 1. reset with garbage inputs
        reset = 1'b1;
        drive(1, 16'hdead, 1, 4'hf, 1, 2'b11, 1);
        @(negedge clk);
        compare_all();
        tick();
        tick();
        reset = 1'b0;
        #1;
        compare_all();
        check("t1_in_ready_after", in_ready, 1);
        check("t1_out_valid_after", out_valid, 0);

        // 2. single push, out_ready low
        drive(1, 16'h1234, 0, 4'd3, 1, 2'b00, 0);
        tick();
        check("t2_out_valid", out_valid, 1);
        check("t2_out_result", out_result, 16'h1234);
        check("t2_fwd_dest", fwd_dest, 3);
        check("t2_fwd_valid", fwd_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();

        // 3. fill to full, third held, then drain in order
        do_reset();
        drive(1, 16'h0a01, 0, 4'd1, 1, 2'b00, 0); tick();
        drive(1, 16'h0a02, 0, 4'd2, 1, 2'b00, 0); tick();
        check("t3_full_in_ready", in_ready, 0);
        drive(1, 16'h0a03, 0, 4'd3, 1, 2'b00, 0); tick();
        check("t3_held_tail", fwd_result, 16'h0a02);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        tick();
        check("t3_retire", retire_count, 2);
        check("t3_empty", out_valid, 0);

        // 4. branch decode and r0 suppression
        drive(1, 16'h0000, 1, 4'd5, 1, 2'b01, 0); tick();
        check("t4_br01_z1", out_br_taken, 1);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 16'h0000, 1, 4'd5, 1, 2'b10, 0); tick();
        check("t4_br10_z1", out_br_taken, 0);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 16'h0077, 0, 4'd5, 1, 2'b11, 0); tick();
        check("t4_br11", out_br_taken, 1);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 16'h0088, 0, 4'd0, 1, 2'b00, 0); tick();
        check("t4_r0_wr", out_wr_en, 0);
        check("t4_r0_fwd", fwd_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 1); tick();

        // 5. count == 1 with simultaneous push and pop
        drive(1, 16'h5000, 0, 4'd7, 1, 2'b00, 0); tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 16'h5000 + 16'(i), 0, 4'd7, 1, 2'b00, 1);
            tick();
            check("t5_out_valid", out_valid, 1);
            check("t5_in_ready", in_ready, 1);
            check("t5_result", out_result, 16'h5000 + 16'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 1); tick();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
                  4'($urandom), $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1));
            tick();
        end
        reset = 1'b0;

        // 6. retire_count wrap, then reset with entries buffered
        do_reset();
        drive(1, 16'h0001, 0, 4'd1, 1, 2'b00, 0); tick();
        for (int i = 0; i < 65535; i++) begin
            drive(1, 16'(i), 0, 4'd2, 1, 2'b00, 1);
            tick();
        end
        check("t6_retire_ffff", retire_count, 16'hffff);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        check("t6_retire_wrap", retire_count, 0);
        drive(1, 16'h00a1, 0, 4'd1, 1, 2'b00, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 16'h00b1, 0, 4'd1, 1, 2'b00, 0); tick();
        drive(1, 16'h00b2, 0, 4'd2, 1, 2'b00, 0); tick();
        check("t6_two_buffered", in_ready, 0);
        check("t6_retire_before", retire_count, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        reset = 1'b0;
        #1;
        compare_all();
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_no_retire", retire_count, 0);
        tick();
        check("t6_still_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
